reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: turns a kill request from the access monitor into a
// fixed-length CPU reset pulse, waits for the CPU to reach its reset handler,
// then acknowledges. It also keeps a small log of the kill history (count,
// cause bits, PC at kill), which can be read through a simple log port.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   kill_req            level kill request
//   kill_cause[2:0]     violation bits (0: sdata, 1: illegal SW write, 2: CTR/SCACHE write)
//   pc[15:0]            current CPU program counter
//   log_addr[15:0]      log read address
//   log_rd              log read strobe
//   cpu_rst             registered CPU reset, held for HOLD_CYCLES cycles per kill
//   kill_ack            one-cycle pulse when the CPU reaches RESET_HANDLER
//   busy                high whenever a kill sequence is in progress
//   log_dout[15:0]      registered log read data (LOG_BASE: {count,5'b0,cause}; LOG_BASE+2: kill_pc)
//
// Build option: define RESET_LOG_CLEAR_EN to make a read at LOG_BASE clear
// count and cause after returning them; otherwise the log is sticky until reset.

module reset_sequencer #(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter logic [15:0] RESET_HANDLER = 16'hFFFE,
  parameter logic [15:0] LOG_BASE      = 16'h0190
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        kill_req,
  input  logic [2:0]  kill_cause,
  input  logic [15:0] pc,
  input  logic [15:0] log_addr,
  input  logic        log_rd,
  output logic        cpu_rst,
  output logic        kill_ack,
  output logic        busy,
  output logic [15:0] log_dout
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CAUSE_W = 3;
  localparam int unsigned DATA_W = 16;

  localparam logic [CNT_W-1:0]  HOLD_INIT   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  COUNT_MAX   = {CNT_W{1'b1}};
  localparam logic [DATA_W-1:0] LOG_PC_ADDR = DATA_W'(LOG_BASE + 16'd2);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ASSERT       = 2'd1,
    HOLD         = 2'd2,
    WAIT_HANDLER = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]   hold_cnt;
  logic [CNT_W-1:0]   count;
  logic [CAUSE_W-1:0] cause;
  logic [DATA_W-1:0]  kill_pc;

  logic cpu_rst_nxt;
  logic kill_ack_nxt;
  logic start_kill;
  logic in_hold;
  logic rd_stat;
  logic rd_pc;

  assign start_kill = (state == IDLE) && kill_req;
  assign in_hold    = (state == ASSERT) || (state == HOLD);
  assign rd_stat    = log_rd && (log_addr == LOG_BASE);
  assign rd_pc      = log_rd && (log_addr == LOG_PC_ADDR);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (kill_req) state_nxt = ASSERT;
      ASSERT, HOLD: state_nxt = (hold_cnt == '0) ? WAIT_HANDLER : HOLD;
      WAIT_HANDLER: if (pc == RESET_HANDLER) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  // Output decode; values are registered below so cpu_rst tracks the state entered
  always_comb begin
    cpu_rst_nxt  = 1'b0;
    kill_ack_nxt = 1'b0;
    if ((state_nxt == ASSERT) || (state_nxt == HOLD)) begin
      cpu_rst_nxt = 1'b1;
    end
    if ((state == WAIT_HANDLER) && (state_nxt == IDLE)) begin
      kill_ack_nxt = 1'b1;
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rst  <= 1'b0;
      kill_ack <= 1'b0;
      busy     <= 1'b0;
    end else begin
      cpu_rst  <= cpu_rst_nxt;
      kill_ack <= kill_ack_nxt;
      busy     <= (state_nxt != IDLE);
    end
  end

  // Hold down-counter: loaded on kill, counts the remaining reset cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (start_kill) begin
      hold_cnt <= HOLD_INIT;
    end else if (in_hold && (hold_cnt != '0)) begin
      hold_cnt <= hold_cnt - CNT_W'(1);
    end
  end

  // Kill log: cause accumulates on any request, count/pc only on a fresh kill
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      cause   <= '0;
      kill_pc <= '0;
    end else begin
      if (start_kill) begin
        kill_pc <= pc;
      end
`ifdef RESET_LOG_CLEAR_EN
      // Read-to-clear; a capture in the same cycle takes precedence
      if (start_kill) begin
        count <= (count == COUNT_MAX) ? count : count + CNT_W'(1);
      end else if (rd_stat) begin
        count <= '0;
      end
      if (kill_req) begin
        cause <= cause | kill_cause;
      end else if (rd_stat) begin
        cause <= '0;
      end
`else
      if (start_kill) begin
        count <= (count == COUNT_MAX) ? count : count + CNT_W'(1);
      end
      if (kill_req) begin
        cause <= cause | kill_cause;
      end
`endif
    end
  end

  // Log read port, one cycle of latency
  always_ff @(posedge clk) begin
    if (reset) begin
      log_dout <= '0;
    end else if (rd_stat) begin
      log_dout <= {count, 5'b0, cause};
    end else if (rd_pc) begin
      log_dout <= kill_pc;
    end else begin
      log_dout <= '0;
    end
  end

endmodule
